// File: rtl/fpu_stream_pkg.sv
// Shared constants for the double operand stream: LFSR feedback mask, exponent field
// bounds, the special-value table and the generator FSM states.
package fpu_stream_pkg;

    localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

    localparam int          EXP_MSB   = 62;
    localparam int          EXP_LSB   = 52;
    localparam logic [10:0] EXP_ALL1  = 11'h7FF;
    localparam logic [10:0] EXP_CLAMP = 11'h7FE;

    localparam logic [63:0] SPECIAL [0:7] = '{
        64'h0000_0000_0000_0000,   // +0
        64'h8000_0000_0000_0000,   // -0
        64'h7FF0_0000_0000_0000,   // +inf
        64'hFFF0_0000_0000_0000,   // -inf
        64'h7FF8_0000_0000_0000,   // qNaN
        64'h0000_0000_0000_0001,   // min denormal
        64'h7FEF_FFFF_FFFF_FFFF,   // max normal
        64'h3FF0_0000_0000_0000    // one
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GENERATE,
        ST_SEND,
        ST_FINISH
    } state_e;

    // Keeps the random stream finite: an all-ones exponent becomes the largest finite one.
    function automatic logic [63:0] clamp_exp(input logic [63:0] v);
        logic [63:0] r;
        r = v;
        if (v[EXP_MSB:EXP_LSB] == EXP_ALL1)
            r[EXP_MSB:EXP_LSB] = EXP_CLAMP;
        return r;
    endfunction

endpackage

// File: rtl/double_lfsr.sv
// 64-bit Galois LFSR that advances one step whenever step is high.
// A zero seed would lock the register at zero, so it is replaced by 1.
module double_lfsr
    import fpu_stream_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [63:0] state
);

    localparam logic [63:0] SEED_FIX = (SEED == 64'h0) ? 64'h1 : SEED;

    logic [63:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (step)
            state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_MASK : 64'h0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= SEED_FIX;
        else
            state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/double_operand_source.sv
// Pseudo-random double operand pair transmitter over two stb/ack channels.
// Define SPECIALS_EN to substitute a special value on channel b every 16th pair.
module double_operand_source
    import fpu_stream_pkg::*;
#(
    parameter logic [63:0] SEED_A = 64'h0000_0000_0000_0001,
    parameter logic [63:0] SEED_B = 64'h0000_0000_0000_0002,
    parameter logic [31:0] COUNT  = 32'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [63:0] output_a,
    output logic        output_a_stb,
    input  logic        output_a_ack,
    output logic [63:0] output_b,
    output logic        output_b_stb,
    input  logic        output_b_ack,
    output logic        done,
    output logic [31:0] pairs_sent
);

    state_e      fsm_q, fsm_d;
    logic [63:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic        stb_a_q, stb_a_d, stb_b_q, stb_b_d;
    logic        done_q, done_d;
    logic [31:0] pairs_q, pairs_d;
    logic        lfsr_step;
    logic [63:0] lfsr_a, lfsr_b;
    logic        a_free, b_free;

    double_lfsr #(.SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_a)
    );

    double_lfsr #(.SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_b)
    );

    // The LFSRs advance on every transition into GENERATE, so in GENERATE they
    // already hold the freshly stepped value that is loaded onto the channels.
    always_comb begin
        fsm_d     = fsm_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        stb_a_d   = stb_a_q;
        stb_b_d   = stb_b_q;
        done_d    = done_q;
        pairs_d   = pairs_q;
        lfsr_step = 1'b0;
        a_free    = !stb_a_q || output_a_ack;
        b_free    = !stb_b_q || output_b_ack;

        case (fsm_q)
            ST_IDLE: begin
                if (enable) begin
                    fsm_d     = ST_GENERATE;
                    lfsr_step = 1'b1;
                end
            end
            ST_GENERATE: begin
                out_a_d = clamp_exp(lfsr_a);
`ifdef SPECIALS_EN
                if (pairs_q[3:0] == 4'hF)
                    out_b_d = SPECIAL[pairs_q[6:4]];
                else
                    out_b_d = clamp_exp(lfsr_b);
`else
                out_b_d = clamp_exp(lfsr_b);
`endif
                stb_a_d = 1'b1;
                stb_b_d = 1'b1;
                fsm_d   = ST_SEND;
            end
            ST_SEND: begin
                if (stb_a_q && output_a_ack)
                    stb_a_d = 1'b0;
                if (stb_b_q && output_b_ack)
                    stb_b_d = 1'b0;
                if (a_free && b_free) begin
                    pairs_d = pairs_q + 32'd1;
                    if (pairs_d == COUNT) begin
                        fsm_d  = ST_FINISH;
                        done_d = 1'b1;
                    end else begin
                        fsm_d     = ST_GENERATE;
                        lfsr_step = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                stb_a_d = 1'b0;
                stb_b_d = 1'b0;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= ST_IDLE;
            out_a_q <= 64'h0;
            out_b_q <= 64'h0;
            stb_a_q <= 1'b0;
            stb_b_q <= 1'b0;
            done_q  <= 1'b0;
            pairs_q <= 32'h0;
        end else begin
            fsm_q   <= fsm_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            stb_a_q <= stb_a_d;
            stb_b_q <= stb_b_d;
            done_q  <= done_d;
            pairs_q <= pairs_d;
        end
    end

    assign output_a     = out_a_q;
    assign output_b     = out_b_q;
    assign output_a_stb = stb_a_q;
    assign output_b_stb = stb_b_q;
    assign done         = done_q;
    assign pairs_sent   = pairs_q;

endmodule

// File: tb/tb_double_operand_source.sv
// Scoreboard bench for double_operand_source: expected pairs are queued from a
// plain-arithmetic LFSR model and popped by a monitor on every channel transfer.
module tb_double_operand_source;

    localparam logic [63:0] SEED_A = 64'h1;
    localparam logic [63:0] SEED_B = 64'h2;
    localparam int          COUNT  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        ack_a = 1'b0, ack_b = 1'b0;
    logic [63:0] output_a, output_b;
    logic        output_a_stb, output_b_stb, done;
    logic [31:0] pairs_sent;

    double_operand_source #(.SEED_A(SEED_A), .SEED_B(SEED_B), .COUNT(COUNT)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .output_a     (output_a),
        .output_a_stb (output_a_stb),
        .output_a_ack (ack_a),
        .output_b     (output_b),
        .output_b_stb (output_b_stb),
        .output_b_ack (ack_b),
        .done         (done),
        .pairs_sent   (pairs_sent)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int na, nb;

    function automatic logic [63:0] next_rand(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    function automatic logic [63:0] finite(input logic [63:0] v);
        logic [63:0] r;
        r = v;
        if (v[62:52] == 11'h7FF) r[62:52] = 11'h7FE;
        return r;
    endfunction

    function automatic logic [63:0] special_val(input int i);
        case (i)
            0: return 64'h0000_0000_0000_0000;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h7FF0_0000_0000_0000;
            3: return 64'hFFF0_0000_0000_0000;
            4: return 64'h7FF8_0000_0000_0000;
            5: return 64'h0000_0000_0000_0001;
            6: return 64'h7FEF_FFFF_FFFF_FFFF;
            default: return 64'h3FF0_0000_0000_0000;
        endcase
    endfunction

    task automatic fill();
        logic [63:0] sa, sb, vb;
        qa.delete();
        qb.delete();
        na = 0;
        nb = 0;
        sa = (SEED_A == 64'h0) ? 64'h1 : SEED_A;
        sb = (SEED_B == 64'h0) ? 64'h1 : SEED_B;
        for (int k = 0; k < COUNT; k++) begin
            sa = next_rand(sa);
            sb = next_rand(sb);
            vb = finite(sb);
`ifdef SPECIALS_EN
            if (k % 16 == 15) vb = special_val((k / 16) % 8);
`endif
            qa.push_back(finite(sa));
            qb.push_back(vb);
        end
    endtask

    function automatic int min2(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // ---------------- ack driver ----------------
    int ack_mode = 3;   // 0 low, 1 high, 2 b delayed 5 cycles, 3 random
    int b_wait = 0;

    always begin
        @(posedge clk);
        #1;
        case (ack_mode)
            0: begin ack_a = 1'b0; ack_b = 1'b0; end
            1: begin ack_a = 1'b1; ack_b = 1'b1; end
            2: begin
                ack_a = 1'b1;
                if (output_b_stb) b_wait++; else b_wait = 0;
                ack_b = (b_wait >= 5);
            end
            default: begin
                ack_a = 1'($urandom_range(0, 1));
                ack_b = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // ---------------- monitor ----------------
    logic        p_valid = 1'b0;
    logic        p_stb_a, p_ack_a, p_stb_b, p_ack_b;
    logic [63:0] p_a, p_b;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_stb_a", output_a_stb, 0);
            check("rst_stb_b", output_b_stb, 0);
            check("rst_done", done, 0);
            check("rst_pairs", pairs_sent, 0);
            check("rst_out_a", output_a, 0);
            check("rst_out_b", output_b, 0);
            p_valid = 1'b0;
        end else begin
            if (p_valid && p_stb_a && !p_ack_a) begin
                check("hold_stb_a", output_a_stb, 1);
                check("hold_a", output_a, p_a);
            end
            if (p_valid && p_stb_b && !p_ack_b) begin
                check("hold_stb_b", output_b_stb, 1);
                check("hold_b", output_b, p_b);
            end
            check("pairs_sent", pairs_sent, 64'(min2(na, nb)));
            check("done_flag", done, (min2(na, nb) == COUNT) ? 64'd1 : 64'd0);
            if (done) check("done_stbs", {output_a_stb, output_b_stb}, 0);
            if (output_a_stb) begin
                check("finite_a", (output_a[62:52] == 11'h7FF) ? 64'd1 : 64'd0, 0);
                if (ack_a) begin
                    if (qa.size() == 0) check("extra_a", 1, 0);
                    else check("data_a", output_a, qa.pop_front());
                    na++;
                end
            end
            if (output_b_stb) begin
`ifndef SPECIALS_EN
                check("finite_b", (output_b[62:52] == 11'h7FF) ? 64'd1 : 64'd0, 0);
`endif
                if (ack_b) begin
                    if (qb.size() == 0) check("extra_b", 1, 0);
                    else check("data_b", output_b, qb.pop_front());
                    nb++;
                end
            end
            p_valid = 1'b1;
            p_stb_a = output_a_stb; p_ack_a = ack_a; p_a = output_a;
            p_stb_b = output_b_stb; p_ack_b = ack_b; p_b = output_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] p0;
        logic        seen;
        logic        found;

        fill();
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Release reset with enable low: generator must stay idle.
        #2 rst = 1'b1;
        ack_mode = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle_stb_a", output_a_stb, 0);
        check("idle_stb_b", output_b_stb, 0);
        check("idle_pairs", pairs_sent, 0);

        // Acks held high: first operand and two-cycle pair rate.
        @(posedge clk);
        #2 enable = 1'b1;
        ack_mode = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("first_a", output_a, 64'hD800_0000_0000_0000);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("throughput", pairs_sent, 10);

        // Channel b acknowledged late: a finishes first, b must wait.
        @(posedge clk);
        #2 ack_mode = 2;
        p0 = pairs_sent;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (output_b_stb && !output_a_stb) seen = 1'b1;
        end
        check("a_before_b", seen, 1);
        for (int i = 0; i < 60 && pairs_sent < p0 + 2; i++) @(negedge clk);
        check("delay_progress", (pairs_sent >= p0 + 2) ? 64'd1 : 64'd0, 1);

        // Random stalls until the final pair.
        ack_mode = 3;
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        check("reach_done", done, 1);
        check("final_pairs", pairs_sent, COUNT);
        check("final_na", na, COUNT);
        check("final_nb", nb, COUNT);
        ack_mode = 1;
        repeat (10) @(negedge clk);
        check("late_ack_na", na, COUNT);
        check("late_ack_pairs", pairs_sent, COUNT);
        check("late_done", done, 1);

        // Restart, then reset in the middle of a SEND.
        @(posedge clk);
        #2 rst = 1'b0;
        fill();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        ack_mode = 3;
        for (int i = 0; i < 400 && pairs_sent < 5; i++) @(negedge clk);
        check("restart_progress", (pairs_sent >= 5) ? 64'd1 : 64'd0, 1);
        ack_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (output_a_stb && output_b_stb && !ack_a && !ack_b) found = 1'b1;
        end
        check("pre_rst_stbs", {output_a_stb, output_b_stb}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("async_drop_a", output_a_stb, 0);
        check("async_drop_b", output_b_stb, 0);
        check("async_pairs", pairs_sent, 0);
        fill();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        ack_mode = 3;
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        check("rerun_done", done, 1);
        check("rerun_pairs", pairs_sent, COUNT);
        check("rerun_nb", nb, COUNT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
